quiz_round_sequencer: RTL and testbench

//   Top-level round sequencer for the factorization quiz. Per question: requests a new problem from the

---
 rtl/quiz_round_sequencer_if.sv | 25 ++
 rtl/quiz_round_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_quiz_round_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quiz_round_sequencer_if.sv
// Handshake bundle between the round sequencer, the question generator and the judge unit.
// The sequencer owns the request lines; the generator/judge side answers with ack/valid/ok.
interface quiz_round_sequencer_if;
  logic qgen_req;
  logic qgen_ack;
  logic judg_req;
  logic judg_valid;
  logic judg_ok;

  modport master (
    output qgen_req,
    output judg_req,
    input  qgen_ack,
    input  judg_valid,
    input  judg_ok
  );

  modport slave (
    input  qgen_req,
    input  judg_req,
    output qgen_ack,
    output judg_valid,
    output judg_ok
  );
endinterface

// File: rtl/quiz_round_sequencer.sv
// Round sequencer for the factorization quiz: question request, countdown, judgement,
// scoring and result display, ending the game on HP exhaustion or a full clear.
module quiz_round_sequencer #(
  parameter int HP_INIT    = 3,
  parameter int Q_NUM      = 5,
  parameter int TIME_LIMIT = 9,
  parameter int SHOW_SEC   = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_tick_1s,
  input  logic                          i_dec,
  quiz_round_sequencer_if.master        bus,
  output logic [2:0]                    o_state,
  output logic [1:0]                    o_hp,
  output logic [2:0]                    o_cnt,
  output logic [3:0]                    o_timer,
  output logic [1:0]                    o_result,
  output logic                          o_need_1sec,
  output logic                          o_clr_out,
  output logic                          o_over_out
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_Q  = 3'd1,
    ST_ANSWER = 3'd2,
    ST_JUDGE  = 3'd3,
    ST_SHOW   = 3'd4,
    ST_OVER   = 3'd5,
    ST_CLEAR  = 3'd6
  } state_t;

  localparam logic [1:0] HP_INIT_V   = 2'(HP_INIT);
  localparam logic [2:0] Q_NUM_V     = 3'(Q_NUM);
  localparam logic [3:0] TIME_LIM_V  = 4'(TIME_LIMIT);
  localparam logic [1:0] SHOW_LAST_V = 2'(SHOW_SEC - 1);

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_OK      = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  state_t     r_state,     w_state_nxt;
  logic [1:0] r_hp,        w_hp_nxt;
  logic [2:0] r_cnt,       w_cnt_nxt;
  logic [3:0] r_timer,     w_timer_nxt;
  logic [1:0] r_result,    w_result_nxt;
  logic [1:0] r_show_cnt,  w_show_cnt_nxt;
  logic       r_qgen_req,  w_qgen_req_nxt;
  logic       r_judg_req,  w_judg_req_nxt;
  logic       r_need_1sec, w_need_1sec_nxt;
  logic       r_clr,       w_clr_nxt;
  logic       r_over,      w_over_nxt;

  function automatic logic [1:0] hp_dec_sat(input logic [1:0] hp);
    logic [1:0] res;
    if (hp == 2'd0) begin
      res = 2'd0;
    end else begin
      res = hp - 2'd1;
    end
    return res;
  endfunction

  function automatic logic [3:0] timer_dec_sat(input logic [3:0] t);
    logic [3:0] res;
    if (t == 4'd0) begin
      res = 4'd0;
    end else begin
      res = t - 4'd1;
    end
    return res;
  endfunction

  // Next-state, scoring and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_hp_nxt       = r_hp;
    w_cnt_nxt      = r_cnt;
    w_timer_nxt    = r_timer;
    w_result_nxt   = r_result;
    w_show_cnt_nxt = r_show_cnt;

    case (r_state)
      ST_IDLE, ST_OVER, ST_CLEAR: begin
        if (i_start) begin
          w_state_nxt  = ST_REQ_Q;
          w_hp_nxt     = HP_INIT_V;
          w_cnt_nxt    = 3'd0;
          w_result_nxt = RES_NONE;
        end else begin
          w_state_nxt  = r_state;
        end
      end
      ST_REQ_Q: begin
        // An ack only counts once our request is actually visible on the bus.
        if (r_qgen_req && bus.qgen_ack) begin
          w_state_nxt = ST_ANSWER;
          w_timer_nxt = TIME_LIM_V;
        end else begin
          w_state_nxt = ST_REQ_Q;
        end
      end
      ST_ANSWER: begin
        if (i_dec) begin
          w_state_nxt = ST_JUDGE;
        end else if (i_tick_1s) begin
          w_timer_nxt = timer_dec_sat(r_timer);
          if (r_timer <= 4'd1) begin
            w_state_nxt    = ST_SHOW;
            w_result_nxt   = RES_TIMEOUT;
            w_hp_nxt       = hp_dec_sat(r_hp);
            w_show_cnt_nxt = 2'd0;
          end else begin
            w_state_nxt    = ST_ANSWER;
          end
        end else begin
          w_state_nxt = ST_ANSWER;
        end
      end
      ST_JUDGE: begin
        if (bus.judg_valid) begin
          w_state_nxt    = ST_SHOW;
          w_show_cnt_nxt = 2'd0;
          if (bus.judg_ok) begin
            w_result_nxt = RES_OK;
            w_cnt_nxt    = r_cnt + 3'd1;
          end else begin
            w_result_nxt = RES_WRONG;
            w_hp_nxt     = hp_dec_sat(r_hp);
          end
        end else begin
          w_state_nxt = ST_JUDGE;
        end
      end
      ST_SHOW: begin
        if (i_tick_1s) begin
          if (r_show_cnt == SHOW_LAST_V) begin
            w_show_cnt_nxt = 2'd0;
            if (r_hp == 2'd0) begin
              w_state_nxt  = ST_OVER;
            end else if (r_cnt == Q_NUM_V) begin
              w_state_nxt  = ST_CLEAR;
            end else begin
              w_state_nxt  = ST_REQ_Q;
              w_result_nxt = RES_NONE;
            end
          end else begin
            w_show_cnt_nxt = r_show_cnt + 2'd1;
          end
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The generator request trails state entry by one cycle and drops right after the ack.
    w_qgen_req_nxt  = (r_state == ST_REQ_Q) && (w_state_nxt == ST_REQ_Q);
    w_judg_req_nxt  = (w_state_nxt == ST_JUDGE);
    w_need_1sec_nxt = (w_state_nxt == ST_SHOW);
    w_clr_nxt       = (w_state_nxt == ST_CLEAR);
    w_over_nxt      = (w_state_nxt == ST_OVER);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_hp        <= HP_INIT_V;
      r_cnt       <= 3'd0;
      r_timer     <= 4'd0;
      r_result    <= RES_NONE;
      r_show_cnt  <= 2'd0;
      r_qgen_req  <= 1'b0;
      r_judg_req  <= 1'b0;
      r_need_1sec <= 1'b0;
      r_clr       <= 1'b0;
      r_over      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hp        <= w_hp_nxt;
      r_cnt       <= w_cnt_nxt;
      r_timer     <= w_timer_nxt;
      r_result    <= w_result_nxt;
      r_show_cnt  <= w_show_cnt_nxt;
      r_qgen_req  <= w_qgen_req_nxt;
      r_judg_req  <= w_judg_req_nxt;
      r_need_1sec <= w_need_1sec_nxt;
      r_clr       <= w_clr_nxt;
      r_over      <= w_over_nxt;
    end
  end

  assign bus.qgen_req = r_qgen_req;
  assign bus.judg_req = r_judg_req;
  assign o_state      = r_state;
  assign o_hp         = r_hp;
  assign o_cnt        = r_cnt;
  assign o_timer      = r_timer;
  assign o_result     = r_result;
  assign o_need_1sec  = r_need_1sec;
  assign o_clr_out    = r_clr;
  assign o_over_out   = r_over;

endmodule

// File: tb/tb_quiz_round_sequencer.sv
// Self-checking bench for quiz_round_sequencer: randomized rounds checked against a
// game-level expectation model updated from the rules of the quiz.
module tb_quiz_round_sequencer;
  localparam int HP_INIT = 3;
  localparam int Q_NUM = 5;
  localparam int TL = 9;
  localparam int SHOW_SEC = 1;

  logic clk = 1'b0;
  logic rst, start, tick, dec;
  logic [2:0] state;
  logic [1:0] hp;
  logic [2:0] cnt;
  logic [3:0] timer;
  logic [1:0] result;
  logic need_1sec, clr_out, over_out;

  quiz_round_sequencer_if bus ();

  quiz_round_sequencer #(
    .HP_INIT(HP_INIT), .Q_NUM(Q_NUM), .TIME_LIMIT(TL), .SHOW_SEC(SHOW_SEC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tick_1s(tick), .i_dec(dec),
    .bus(bus),
    .o_state(state), .o_hp(hp), .o_cnt(cnt), .o_timer(timer), .o_result(result),
    .o_need_1sec(need_1sec), .o_clr_out(clr_out), .o_over_out(over_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected values: game state as the rules describe it
  int e_state, e_hp, e_cnt, e_timer, e_result;
  int e_qreq, e_jreq, e_need, e_clr, e_over;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(state), e_state);
    chk({tag, ".hp"}, 32'(hp), e_hp);
    chk({tag, ".cnt"}, 32'(cnt), e_cnt);
    chk({tag, ".timer"}, 32'(timer), e_timer);
    chk({tag, ".result"}, 32'(result), e_result);
    chk({tag, ".qgen_req"}, 32'(bus.qgen_req), e_qreq);
    chk({tag, ".judg_req"}, 32'(bus.judg_req), e_jreq);
    chk({tag, ".need_1sec"}, 32'(need_1sec), e_need);
    chk({tag, ".clr_out"}, 32'(clr_out), e_clr);
    chk({tag, ".over_out"}, 32'(over_out), e_over);
  endtask

  task automatic exp_reset();
    e_state = 0; e_hp = HP_INIT; e_cnt = 0; e_timer = 0; e_result = 0;
    e_qreq = 0; e_jreq = 0; e_need = 0; e_clr = 0; e_over = 0;
  endtask

  // One clock: inputs were set before the call, outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0; dec = 1'b0;
    bus.qgen_ack = 1'b0; bus.judg_valid = 1'b0; bus.judg_ok = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom_range(0, 1));
      cyc();
      chk_all(tag);
    end
  endtask

  task automatic lose_hp();
    e_hp = (e_hp > 0) ? e_hp - 1 : 0;
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    e_state = 1; e_hp = HP_INIT; e_cnt = 0; e_result = 0;
    e_qreq = 0; e_jreq = 0; e_need = 0; e_clr = 0; e_over = 0;
    chk_all("start");
  endtask

  task automatic request_q();
    bus.qgen_ack = 1'($urandom_range(0, 1));
    cyc();
    e_qreq = 1;
    chk_all("req_rise");
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      tick = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      cyc();
      chk_all("req_hold");
    end
    bus.qgen_ack = 1'b1;
    cyc();
    e_state = 2; e_qreq = 0; e_timer = TL;
    chk_all("req_ack");
  endtask

  // mode 0: answer after random ticks, 1: let the timer run out, 2: DEC together with the final tick
  task automatic answer_round(input int mode, input bit ok);
    int k;
    k = (mode == 1) ? TL : (mode == 2) ? TL - 1 : int'($urandom_range(0, TL - 1));
    for (int j = 0; j < k; j++) begin
      idle(int'($urandom_range(0, 2)), "ans_idle");
      tick = 1'b1;
      cyc();
      e_timer = e_timer - 1;
      if (e_timer == 0) begin
        e_state = 4; e_result = 3; e_need = 1;
        lose_hp();
      end
      chk_all("tick");
    end
    if (mode != 1) begin
      idle(int'($urandom_range(0, 1)), "ans_idle");
      dec = 1'b1;
      if (e_timer == 1) tick = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      e_state = 3; e_jreq = 1;
      chk_all("dec");
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        tick = 1'($urandom_range(0, 1));
        dec = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        bus.judg_ok = 1'($urandom_range(0, 1));
        cyc();
        chk_all("judge_wait");
      end
      bus.judg_valid = 1'b1;
      bus.judg_ok = ok;
      tick = 1'($urandom_range(0, 1));
      cyc();
      e_state = 4; e_jreq = 0; e_need = 1;
      if (ok) begin
        e_result = 1; e_cnt = e_cnt + 1;
      end else begin
        e_result = 2; lose_hp();
      end
      chk_all("verdict");
    end
    for (int s = 0; s < SHOW_SEC; s++) begin
      idle(int'($urandom_range(0, 2)), "show_idle");
      tick = 1'b1;
      cyc();
      if (s == SHOW_SEC - 1) begin
        e_need = 0;
        if (e_hp == 0) begin
          e_state = 5; e_over = 1;
        end else if (e_cnt == Q_NUM) begin
          e_state = 6; e_clr = 1;
        end else begin
          e_state = 1; e_result = 0;
        end
      end
      chk_all("show_tick");
    end
  endtask

  task automatic hold_end();
    for (int i = 0; i < 3; i++) begin
      tick = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      bus.qgen_ack = 1'($urandom_range(0, 1));
      bus.judg_valid = 1'($urandom_range(0, 1));
      cyc();
      chk_all("end_hold");
    end
  endtask

  initial begin
    int rounds;
    rst = 1'b1; start = 1'b0; tick = 1'b0; dec = 1'b0;
    bus.qgen_ack = 1'b0; bus.judg_valid = 1'b0; bus.judg_ok = 1'b0;
    cyc();
    cyc();
    exp_reset();
    chk_all("reset");
    rst = 1'b0;

    // Stray inputs in IDLE have no effect
    tick = 1'b1; dec = 1'b1; bus.qgen_ack = 1'b1; bus.judg_valid = 1'b1; bus.judg_ok = 1'b1;
    cyc();
    chk_all("idle_stray");

    // Game A: correct, timeout, boundary DEC+tick, then random rounds to the end
    start_game();
    request_q(); answer_round(0, 1'b1);
    request_q(); answer_round(1, 1'b0);
    request_q(); answer_round(2, 1'($urandom_range(0, 1)));
    rounds = 0;
    while (e_state != 5 && e_state != 6 && rounds < 20) begin
      request_q();
      answer_round(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      rounds++;
    end
    hold_end();

    // Game B: all correct -> clear
    start_game();
    for (int r = 0; r < Q_NUM; r++) begin
      request_q();
      answer_round((r == 2) ? 2 : 0, 1'b1);
    end
    chk("clear.state", 32'(state), 6);
    hold_end();

    // Game C: all timeouts -> over, HP held at zero
    start_game();
    for (int r = 0; r < HP_INIT; r++) begin
      request_q();
      answer_round(1, 1'b0);
    end
    chk("over.state", 32'(state), 5);
    hold_end();

    // Reset in the middle of a judgement; a late verdict must be ignored
    start_game();
    request_q();
    dec = 1'b1;
    cyc();
    e_state = 3; e_jreq = 1;
    chk_all("rst_pre");
    rst = 1'b1; bus.judg_valid = 1'b1; bus.judg_ok = 1'b1; start = 1'b1;
    cyc();
    exp_reset();
    chk_all("rst_judge");
    rst = 1'b0;
    bus.judg_valid = 1'b1; bus.judg_ok = 1'b1; bus.qgen_ack = 1'b1;
    cyc();
    chk_all("rst_late");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
